systolic_writeback: RTL and testbench
=====================================

Name: systolic_writeback

Overview:
- Downstream stage of the systolic-array matrix-multiply driver.
- On the driver's completion pulse it snapshots the N×N result tile.
- It then writes the tile to memory one row per beat, at base address plus row times row stride, with per-column write masking for partial edge tiles.
- Frees the array to start the next tile while the writeback drains.

Parameters:
- N, 8, tile dimension. Must equal `BANDWIDTH; one memory beat carries one full tile row.
- CNT_W, 4, width of the rows_valid and cols_valid inputs. Must satisfy 2^CNT_W > N.

Ports:
- clock  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; connect to the driver's done
- tile  input  N×N×`DATA_WIDTH  result tile, indexed [row][col]; sampled only on an accepted start
- base_C  input  `ADDR_WIDTH  address of tile row 0
- dim_col_C  input  `DIM_WIDTH  row stride in beats
- rows_valid  input  CNT_W  number of rows to write (0..N)
- cols_valid  input  CNT_W  number of valid columns per row (0..N)
- write  output  1  write request
- write_addr  output  `ADDR_WIDTH  beat address
- writedata  output  N×`DATA_WIDTH  row data; word j is column j
- writemask  output  N  bit j set means word j is written
- write_wait  input  1  memory stall; a beat is accepted in a cycle where write=1 and write_wait=0
- busy  output  1  high from the accepted start through the done cycle
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset (asynchronous, on reset_n low): state IDLE; write, busy and done are 0; write_addr, writedata and writemask are 0; the tile buffer and all latched fields are cleared.
- Reset asserted mid-tile: the operation aborts at once and no further beats are issued. A beat that was pending is withdrawn.
- States: IDLE, WRITE, DONE.
- IDLE, on start:
  - Capture tile, base_C, dim_col_C, and rows_valid and cols_valid, each clamped to N.
  - Clear the row counter r and set the address accumulator to base_C.
  - If either clamped count is 0, go to DONE; otherwise go to WRITE.
- start while not in IDLE: ignored. The buffer and latched fields are not disturbed.
- WRITE:
  - write=1, write_addr = accumulator, writedata = buffer row r, writemask = bits [cols_valid-1:0] set.
  - Masked-off words of writedata are driven 0.
  - On acceptance: r increments and the accumulator adds dim_col_C (modulo 2^`ADDR_WIDTH; wrap is legal and not flagged).
  - If the accepted row was r = rows_valid-1, go to DONE.
  - While write_wait=1, all write outputs hold stable.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE. A start arriving in the DONE cycle is ignored.
- Latency with no stalls: start accepted in cycle 0; row r is presented in cycle 1+r; done is high in cycle rows_valid+1. Each stall cycle adds one cycle.
- Input independence: once a start is accepted, tile and the address inputs may change freely; the block uses only the captured copies.

Optional Feature:
- Macro: SYSTOLIC_WB_RELU_EN.
- Defined: ReLU on output. Any writedata word whose MSB (sign bit) is 1 is driven as 0. Applied after capture, before masking. writemask is unaffected.
- Undefined: writedata carries the captured words unmodified. No extra logic is instantiated.

Test Plan:
- Full tile, no stalls: base_C=0x100, dim_col_C=8, rows=cols=8, tile[r][c]=r*8+c -> addresses 0x100,0x108,…,0x138 in cycles 1..8; writemask=0xFF; done in cycle 9.
- Stall hold: same tile with write_wait=1 on cycles 2–4 -> row 1 at 0x108 held stable for 3 cycles; done in cycle 12; exactly 8 accepted beats.
- Partial tile: rows_valid=3, cols_valid=5 -> 3 beats; writemask=0x1F; words 5..7 are 0; done in cycle 4.
- Degenerate tile: rows_valid=0 (and separately cols_valid=0) -> no write asserted; done in cycle 1. Out-of-range rows_valid=12 -> clamped, exactly 8 beats.
- Busy and reset: start re-pulsed during WRITE with a different tile -> ignored, original data written. reset_n low during row 4 -> write=0 immediately, no done, busy=0.
- Address wrap: base_C=2^`ADDR_WIDTH-8 with dim_col_C=8 -> row 1 at address 0. With SYSTOLIC_WB_RELU_EN defined, word 0xBF800000 (-1.0) is written as 0.

Source files
------------

// File: rtl/systolic_writeback.sv
// Systolic-array writeback: snapshots an NxN result tile on start and streams it to memory one row per beat.
// Optional feature macro SYSTOLIC_WB_RELU_EN zeroes negative output words (ReLU).
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DIM_WIDTH
`define DIM_WIDTH 16
`endif
`ifndef BANDWIDTH
`define BANDWIDTH 8
`endif

module systolic_writeback #(
    parameter int N     = `BANDWIDTH,
    parameter int CNT_W = 4
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic                                 start,
    input  logic [N-1:0][N-1:0][`DATA_WIDTH-1:0] tile,
    input  logic [`ADDR_WIDTH-1:0]               base_C,
    input  logic [`DIM_WIDTH-1:0]                dim_col_C,
    input  logic [CNT_W-1:0]                     rows_valid,
    input  logic [CNT_W-1:0]                     cols_valid,
    output logic                                 write,
    output logic [`ADDR_WIDTH-1:0]               write_addr,
    output logic [N-1:0][`DATA_WIDTH-1:0]        writedata,
    output logic [N-1:0]                         writemask,
    input  logic                                 write_wait,
    output logic                                 busy,
    output logic                                 done
);
    localparam int DW    = `DATA_WIDTH;
    localparam int AW    = `ADDR_WIDTH;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]                  r_state;
    logic [N-1:0][N-1:0][DW-1:0] r_buf;
    logic [AW-1:0]               r_addr;
    logic [`DIM_WIDTH-1:0]       r_stride;
    logic [CNT_W-1:0]            r_rows;
    logic [CNT_W-1:0]            r_cols;
    logic [CNT_W-1:0]            r_row;

    logic [CNT_W-1:0]     w_rowsClamp;
    logic [CNT_W-1:0]     w_colsClamp;
    logic                 w_lastRow;
    logic [IDX_W-1:0]     w_rowIdx;
    logic [N-1:0][DW-1:0] w_rowData;
    logic [N-1:0]         w_mask;

    assign w_rowsClamp = (rows_valid > N_CNT) ? N_CNT : rows_valid;
    assign w_colsClamp = (cols_valid > N_CNT) ? N_CNT : cols_valid;
    assign w_lastRow   = (r_row + CNT_W'(1)) == r_rows;
    assign w_rowIdx    = r_row[IDX_W-1:0];

    // Masked-off columns are driven to zero so stale buffer contents never reach the bus.
    always_comb begin
        w_rowData = '0;
        w_mask    = '0;
        for (int j = 0; j < N; j++) begin
            w_mask[j] = CNT_W'(j) < r_cols;
`ifdef SYSTOLIC_WB_RELU_EN
            w_rowData[j] = (w_mask[j] && !r_buf[w_rowIdx][j][DW-1]) ? r_buf[w_rowIdx][j] : '0;
`else
            w_rowData[j] = w_mask[j] ? r_buf[w_rowIdx][j] : '0;
`endif
        end
    end

    assign write      = (r_state == S_WRITE);
    assign write_addr = write ? r_addr    : '0;
    assign writedata  = write ? w_rowData : '0;
    assign writemask  = write ? w_mask    : '0;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_buf    <= '0;
            r_addr   <= '0;
            r_stride <= '0;
            r_rows   <= '0;
            r_cols   <= '0;
            r_row    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_buf    <= tile;
                        r_addr   <= base_C;
                        r_stride <= dim_col_C;
                        r_rows   <= w_rowsClamp;
                        r_cols   <= w_colsClamp;
                        r_row    <= '0;
                        r_state  <= (w_rowsClamp == '0 || w_colsClamp == '0) ? S_DONE : S_WRITE;
                    end
                end
                S_WRITE: begin
                    // Address accumulation wraps naturally at the address width.
                    if (!write_wait) begin
                        r_row  <= r_row + CNT_W'(1);
                        r_addr <= r_addr + AW'(r_stride);
                        if (w_lastRow) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_writeback.sv
// Self-checking bench for systolic_writeback: queue-based beat model, random stalls/inputs, directed literal checks.
// Honours SYSTOLIC_WB_RELU_EN the same way as the design build.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DIM_WIDTH
`define DIM_WIDTH 16
`endif
`ifndef BANDWIDTH
`define BANDWIDTH 8
`endif

module tb_systolic_writeback;
    localparam int N     = `BANDWIDTH;
    localparam int CNT_W = 4;
    localparam int DW    = `DATA_WIDTH;
    localparam int AW    = `ADDR_WIDTH;
    localparam int DIMW  = `DIM_WIDTH;

    typedef logic [N-1:0][DW-1:0] row_t;
    typedef struct packed {
        logic [AW-1:0] addr;
        row_t          data;
        logic [N-1:0]  mask;
    } beat_t;

    logic                        clock = 1'b0;
    logic                        reset_n;
    logic                        start;
    logic [N-1:0][N-1:0][DW-1:0] tile;
    logic [AW-1:0]               base_C;
    logic [DIMW-1:0]             dim_col_C;
    logic [CNT_W-1:0]            rows_valid;
    logic [CNT_W-1:0]            cols_valid;
    logic                        write;
    logic [AW-1:0]               write_addr;
    row_t                        writedata;
    logic [N-1:0]                writemask;
    logic                        write_wait;
    logic                        busy;
    logic                        done;

    systolic_writeback #(.N(N), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .tile(tile),
        .base_C(base_C), .dim_col_C(dim_col_C), .rows_valid(rows_valid), .cols_valid(cols_valid),
        .write(write), .write_addr(write_addr), .writedata(writedata), .writemask(writemask),
        .write_wait(write_wait), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passes = 0;

    // Expected outputs for the current cycle, set by the stimulus before each falling edge.
    logic  chkEn = 1'b0;
    logic  expWrite, expBusy, expDone, expZero;
    beat_t expBeat;
    beat_t expQ[$];

    // Observations recorded from the DUT for the directed literal checks.
    logic [AW-1:0]    gotAddr[$];
    row_t             gotData[$];
    logic [N-1:0]     gotMask[$];
    logic [AW-1:0]    presAddr[$];
    int               doneCycle;

    task automatic checkOutput(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    always @(negedge clock) begin
        if (chkEn) begin
            checkOutput("write", write, expWrite);
            checkOutput("busy", busy, expBusy);
            checkOutput("done", done, expDone);
            if (expWrite) begin
                checkOutput("write_addr", write_addr, expBeat.addr);
                checkOutput("writedata", writedata, expBeat.data);
                checkOutput("writemask", writemask, expBeat.mask);
            end else if (expZero) begin
                checkOutput("reset_addr", write_addr, '0);
                checkOutput("reset_data", writedata, '0);
                checkOutput("reset_mask", writemask, '0);
            end
        end
    end

    function automatic logic [DW-1:0] relu(input logic [DW-1:0] w);
`ifdef SYSTOLIC_WB_RELU_EN
        return w[DW-1] ? '0 : w;
`else
        return w;
`endif
    endfunction

    // Reference: the tile becomes min(rows,N) beats at base + k*stride, columns beyond min(cols,N) zeroed.
    task automatic buildModel();
        int    rowsC, colsC;
        beat_t b;
        rowsC = (int'(rows_valid) > N) ? N : int'(rows_valid);
        colsC = (int'(cols_valid) > N) ? N : int'(cols_valid);
        expQ.delete();
        if (rowsC == 0 || colsC == 0) return;
        for (int k = 0; k < rowsC; k++) begin
            b.addr = base_C + AW'(k) * AW'(dim_col_C);
            for (int j = 0; j < N; j++) b.data[j] = (j < colsC) ? relu(tile[k][j]) : '0;
            b.mask = N'((1 << colsC) - 1);
            expQ.push_back(b);
        end
    endtask

    task automatic randomInputs();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) tile[r][c] = $urandom;
        base_C     = AW'($urandom);
        dim_col_C  = DIMW'($urandom);
        rows_valid = CNT_W'($urandom_range(0, 15));
        cols_valid = CNT_W'($urandom_range(0, 15));
    endtask

    task automatic fillTile(input logic [AW-1:0] base, input logic [DIMW-1:0] stride, input int rows, input int cols);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) tile[r][c] = DW'(r * 8 + c);
        base_C     = base;
        dim_col_C  = stride;
        rows_valid = CNT_W'(rows);
        cols_valid = CNT_W'(cols);
    endtask

    // One tile: start in cycle 0, then follow the model queue until one idle cycle after done.
    task automatic applyStimulus(input int stallPct, input logic [31:0] stallMask, input bit scramble, input int resetAt);
        bit   doneExp;
        bit   finishing;
        logic stallBit;
        gotAddr.delete(); gotData.delete(); gotMask.delete(); presAddr.delete();
        doneCycle = -1;
        buildModel();
        @(posedge clock); #1;
        start = 1'b1; write_wait = 1'b0;
        expWrite = 0; expBusy = 0; expDone = 0; expZero = 0; chkEn = 1'b1;
        @(negedge clock);
        doneExp = 0;
        for (int t = 1; t < 400; t++) begin
            @(posedge clock); #1;
            start = 1'b0;
            if (scramble) begin
                randomInputs();
                start = ($urandom_range(0, 3) == 0);
            end
            if (t == resetAt) begin
                start = 1'b0; write_wait = 1'b0;
                expWrite = 0; expBusy = 0; expDone = 0; expZero = 1;
                #1 reset_n = 1'b0;
                @(negedge clock);
                #1 reset_n = 1'b1;
                expZero = 0;
                break;
            end
            if (expQ.size() > 0) begin
                expWrite = 1; expBusy = 1; expDone = 0; expBeat = expQ[0];
                stallBit = (t < 32) ? stallMask[t[4:0]] : 1'b0;
                write_wait = stallBit || (t < 100 && $urandom_range(0, 99) < stallPct);
            end else if (!doneExp) begin
                expWrite = 0; expBusy = 1; expDone = 1;
                write_wait = 1'(scramble ? $urandom_range(0, 1) : 0);
            end else begin
                start = 1'b0; write_wait = 1'b0;
                expWrite = 0; expBusy = 0; expDone = 0;
            end
            finishing = (expQ.size() == 0) && doneExp;
            @(negedge clock);
            if (write) presAddr.push_back(write_addr);
            if (write && !write_wait) begin
                gotAddr.push_back(write_addr);
                gotData.push_back(writedata);
                gotMask.push_back(writemask);
            end
            if (done && doneCycle < 0) doneCycle = t;
            if (expWrite && !write_wait) void'(expQ.pop_front());
            if (expDone) doneExp = 1;
            if (finishing) break;
        end
        start = 1'b0; write_wait = 1'b0;
    endtask

    function automatic logic [AW-1:0] addrAt(input int i);
        return (i < gotAddr.size()) ? gotAddr[i] : 'x;
    endfunction

    function automatic row_t dataAt(input int i);
        return (i < gotData.size()) ? gotData[i] : 'x;
    endfunction

    function automatic int countPres(input logic [AW-1:0] a);
        int n = 0;
        foreach (presAddr[i]) if (presAddr[i] == a) n++;
        return n;
    endfunction

    initial begin
        row_t r;
        reset_n = 1'b0; start = 1'b0; write_wait = 1'b0;
        tile = '0; base_C = '0; dim_col_C = '0; rows_valid = '0; cols_valid = '0;
        expWrite = 0; expBusy = 0; expDone = 0; expZero = 1; chkEn = 1'b1;
        @(negedge clock);
        @(negedge clock);
        #1 reset_n = 1'b1;
        expZero = 0;

        // Full tile, no stalls.
        fillTile(AW'(32'h100), DIMW'(8), 8, 8);
        applyStimulus(0, 32'h0, 0, 0);
        checkOutput("full_beats", gotAddr.size(), 8);
        checkOutput("full_addr0", addrAt(0), AW'(32'h100));
        checkOutput("full_addr7", addrAt(7), AW'(32'h138));
        checkOutput("full_mask", (gotMask.size() > 0) ? gotMask[0] : 'x, 8'hFF);
        r = dataAt(3);
        checkOutput("full_data3_5", r[5], 29);
        checkOutput("full_done_cycle", doneCycle, 9);

        // Stall on cycles 2..4 holds row 1.
        fillTile(AW'(32'h100), DIMW'(8), 8, 8);
        applyStimulus(0, 32'h1C, 0, 0);
        checkOutput("stall_beats", gotAddr.size(), 8);
        checkOutput("stall_row1_cycles", countPres(AW'(32'h108)), 4);
        checkOutput("stall_done_cycle", doneCycle, 12);

        // Partial edge tile.
        fillTile(AW'(32'h100), DIMW'(8), 3, 5);
        applyStimulus(0, 32'h0, 0, 0);
        checkOutput("part_beats", gotAddr.size(), 3);
        checkOutput("part_mask", (gotMask.size() > 0) ? gotMask[0] : 'x, 8'h1F);
        r = dataAt(2);
        checkOutput("part_word4", r[4], 20);
        checkOutput("part_word5", r[5], 0);
        checkOutput("part_done_cycle", doneCycle, 4);

        // Degenerate and clamped counts.
        fillTile(AW'(32'h100), DIMW'(8), 0, 8);
        applyStimulus(0, 32'h0, 0, 0);
        checkOutput("rows0_writes", presAddr.size(), 0);
        checkOutput("rows0_done_cycle", doneCycle, 1);
        fillTile(AW'(32'h100), DIMW'(8), 5, 0);
        applyStimulus(0, 32'h0, 0, 0);
        checkOutput("cols0_writes", presAddr.size(), 0);
        checkOutput("cols0_done_cycle", doneCycle, 1);
        fillTile(AW'(32'h100), DIMW'(8), 12, 8);
        applyStimulus(0, 32'h0, 0, 0);
        checkOutput("rows12_beats", gotAddr.size(), 8);

        // Start re-pulsed and inputs changed while busy.
        fillTile(AW'(32'h100), DIMW'(8), 8, 8);
        applyStimulus(0, 32'h0, 1, 0);
        r = dataAt(7);
        checkOutput("repulse_data7_0", r[0], 56);
        checkOutput("repulse_addr7", addrAt(7), AW'(32'h138));

        // Reset while row 4 is presented.
        fillTile(AW'(32'h100), DIMW'(8), 8, 8);
        applyStimulus(0, 32'h0, 0, 5);
        checkOutput("reset_beats", gotAddr.size(), 4);
        checkOutput("reset_no_done", doneCycle, -1);
        fillTile(AW'(32'h100), DIMW'(8), 8, 8);
        applyStimulus(0, 32'h0, 0, 0);
        checkOutput("recover_beats", gotAddr.size(), 8);

        // Address wrap.
        fillTile(AW'(32'hFFFF_FFF8), DIMW'(8), 2, 8);
        applyStimulus(0, 32'h0, 0, 0);
        checkOutput("wrap_addr0", addrAt(0), AW'(32'hFFFF_FFF8));
        checkOutput("wrap_addr1", addrAt(1), AW'(0));

        // Negative word handling.
        fillTile(AW'(32'h200), DIMW'(8), 1, 2);
        tile[0][0] = DW'(32'hBF80_0000);
        tile[0][1] = DW'(32'h3F80_0000);
        applyStimulus(0, 32'h0, 0, 0);
        r = dataAt(0);
`ifdef SYSTOLIC_WB_RELU_EN
        checkOutput("relu_neg", r[0], 0);
`else
        checkOutput("relu_neg", r[0], 32'hBF80_0000);
`endif
        checkOutput("relu_pos", r[1], 32'h3F80_0000);

        // Random tiles with random stalls, re-pulses and input churn.
        for (int i = 0; i < 25; i++) begin
            randomInputs();
            applyStimulus(30, 32'h0, 1, 0);
        end

        chkEn = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
